// File: rtl/calc_input_sequencer.sv
// Keypad-to-ALU sequencer: builds operand A, operator and operand B from key events, then runs one
// valid/ready request and latches the result. Define CALC_CHAIN_EN to chain from a result.
module calc_input_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [3:0]       keycode,
  input  logic             keystrobe,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_sub,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_value,
  input  logic             res_ovf,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_ovf,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned AW = WIDTH + 4;
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_DIGITS);
  localparam logic [AW-1:0] MaxVal = {4'd0, {WIDTH{1'b1}}};

  typedef enum logic [2:0] {StA, StB, StReq, StWait, StRes} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             sub_q, sub_d, dovf_q, dovf_d, err_q, err_d, strobe_q;

  logic             key_evt, is_digit, is_op, is_enter, digit_ok, handshake;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    acc_cnt;
  logic [AW-1:0]    acc_next;

  assign key_evt  = keystrobe & ~strobe_q;
  assign is_digit = keycode <= 4'd9;
  assign is_op    = (keycode == 4'd10) || (keycode == 4'd11);
  assign is_enter = keycode == 4'd12;
  assign acc      = (state_q == StA) ? a_q : b_q;
  assign acc_cnt  = (state_q == StA) ? cnt_a_q : cnt_b_q;
  assign acc_next = {4'd0, acc} * AW'(10) + AW'(keycode);
  assign digit_ok = key_evt & is_digit & (acc_cnt < MaxCnt) & (acc_next <= MaxVal);
  // A key arriving on the same edge as a handshake completion is dropped entirely.
  assign handshake = ((state_q == StReq) & op_ready) | ((state_q == StWait) & res_valid);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    disp_d  = disp_q;
    dovf_d  = dovf_q;
    err_d   = err_q;
    unique case (state_q)
      StA: begin
        if (digit_ok) begin
          a_d     = acc_next[WIDTH-1:0];
          cnt_a_d = cnt_a_q + CW'(1);
          err_d   = 1'b0;
        end else if (key_evt && is_op) begin
          sub_d   = keycode[0];
          b_d     = '0;
          cnt_b_d = '0;
          state_d = StB;
        end
      end
      StB: begin
        if (digit_ok) begin
          b_d     = acc_next[WIDTH-1:0];
          cnt_b_d = cnt_b_q + CW'(1);
          err_d   = 1'b0;
        end else if (key_evt && is_op) begin
          sub_d = keycode[0];
        end else if (key_evt && is_enter && (cnt_b_q != '0)) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (op_ready) state_d = StWait;
      end
      StWait: begin
        if (res_valid) begin
          disp_d  = res_value;
          dovf_d  = res_ovf;
          state_d = StRes;
        end
      end
      StRes: begin
        if (key_evt && is_digit) begin
          a_d     = WIDTH'(keycode);
          cnt_a_d = CW'(1);
          dovf_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StA;
`ifdef CALC_CHAIN_EN
        end else if (key_evt && is_op) begin
          a_d     = disp_q;
          cnt_a_d = MaxCnt;
          sub_d   = keycode[0];
          b_d     = '0;
          cnt_b_d = '0;
          dovf_d  = 1'b0;
          state_d = StB;
`endif
        end
      end
      default: state_d = StA;
    endcase

    if (key_evt && (keycode == 4'd15) && !handshake) err_d = 1'b1;

    unique case (state_d)
      StA:                disp_d = a_d;
      StB, StReq, StWait: disp_d = b_d;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StA;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      disp_q   <= '0;
      dovf_q   <= 1'b0;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      disp_q   <= disp_d;
      dovf_q   <= dovf_d;
      err_q    <= err_d;
      strobe_q <= keystrobe;
    end
  end

  assign op_valid   = state_q == StReq;
  assign busy       = (state_q == StReq) || (state_q == StWait);
  assign op_a       = a_q;
  assign op_b       = b_q;
  assign op_sub     = sub_q;
  assign disp_value = disp_q;
  assign disp_ovf   = dovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: key-press vector table, hand-written handshake/reset sequences and
// randomized presses against an event-level calculator model. Honours CALC_CHAIN_EN.
`timescale 1ns/1ps
module tb_calc_input_sequencer;

  localparam int W    = 8;
  localparam int MAXD = 3;
  localparam int LIM  = (1 << W) - 1;
  localparam int PA = 0, PB = 1, PREQ = 2, PWAIT = 3, PRES = 4;

  logic         clk = 1'b0;
  logic         nrst = 1'b1;
  logic [3:0]   keycode = '0;
  logic         keystrobe = 1'b0;
  logic         op_ready = 1'b0;
  logic         res_valid = 1'b0;
  logic [W-1:0] res_value = '0;
  logic         res_ovf = 1'b0;
  logic         op_valid, op_sub, disp_ovf, err, busy;
  logic [W-1:0] op_a, op_b, disp_value;

  calc_input_sequencer #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .nrst(nrst), .keycode(keycode), .keystrobe(keystrobe),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .res_valid(res_valid), .res_value(res_value), .res_ovf(res_ovf),
    .disp_value(disp_value), .disp_ovf(disp_ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Calculator model: tracks what the user has typed, one press at a time.
  int m_ph, m_a, m_b, m_sub, m_na, m_nb, m_res, m_dovf, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  task m_reset();
    m_ph = PA; m_a = 0; m_b = 0; m_sub = 0; m_na = 0; m_nb = 0;
    m_res = 0; m_dovf = 0; m_err = 0;
  endtask

  task m_key(input int code);
    int v;
    if (code == 15) begin
      m_err = 1;
      return;
    end
    if (m_ph == PA || m_ph == PB) begin
      if (code <= 9) begin
        v = ((m_ph == PA) ? m_a : m_b) * 10 + code;
        if (((m_ph == PA) ? m_na : m_nb) < MAXD && v <= LIM) begin
          if (m_ph == PA) begin m_a = v; m_na++; end
          else begin m_b = v; m_nb++; end
          m_err = 0;
        end
      end else if (code == 10 || code == 11) begin
        m_sub = code - 10;
        if (m_ph == PA) begin m_b = 0; m_nb = 0; m_ph = PB; end
      end else if (code == 12 && m_ph == PB && m_nb > 0) begin
        m_ph = PREQ;
      end
    end else if (m_ph == PRES) begin
      if (code <= 9) begin
        m_a = code; m_na = 1; m_dovf = 0; m_err = 0; m_ph = PA;
      end
`ifdef CALC_CHAIN_EN
      else if (code == 10 || code == 11) begin
        m_a = m_res; m_na = MAXD; m_sub = code - 10; m_b = 0; m_nb = 0; m_dovf = 0; m_ph = PB;
      end
`endif
    end
  endtask

  function automatic int m_show();
    if (m_ph == PA) return m_a;
    if (m_ph == PRES) return m_res;
    return m_b;
  endfunction

  task check_all(input string tag);
    chk({tag, ".op_a"}, op_a, m_a);
    chk({tag, ".op_b"}, op_b, m_b);
    chk({tag, ".op_sub"}, op_sub, m_sub);
    chk({tag, ".disp"}, disp_value, m_show());
    chk({tag, ".dovf"}, disp_ovf, m_dovf);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".busy"}, busy, (m_ph == PREQ || m_ph == PWAIT) ? 1 : 0);
    chk({tag, ".valid"}, op_valid, (m_ph == PREQ) ? 1 : 0);
  endtask

  task press(input int code, input int hold, input int gap);
    keycode   = 4'(code);
    keystrobe = 1'b1;
    repeat (hold) tick();
    keystrobe = 1'b0;
    repeat (gap) tick();
  endtask

  task do_reset();
    keystrobe = 0; op_ready = 0; res_valid = 0;
    #1 nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    m_reset();
  endtask

  typedef struct {
    int code;
    int a;
    int b;
    int sub;
    int disp;
    int err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sum, r, code;

    tbl[0]  = '{1, 1, 0, 0, 1, 0};
    tbl[1]  = '{2, 12, 0, 0, 12, 0};
    tbl[2]  = '{3, 123, 0, 0, 123, 0};
    tbl[3]  = '{4, 123, 0, 0, 123, 0};    // fourth digit dropped
    tbl[4]  = '{12, 123, 0, 0, 123, 0};   // enter ignored in A
    tbl[5]  = '{10, 123, 0, 0, 0, 0};
    tbl[6]  = '{12, 123, 0, 0, 0, 0};     // enter with no B digits
    tbl[7]  = '{2, 123, 2, 0, 2, 0};
    tbl[8]  = '{5, 123, 25, 0, 25, 0};
    tbl[9]  = '{6, 123, 25, 0, 25, 0};    // 256 exceeds range
    tbl[10] = '{15, 123, 25, 0, 25, 1};
    tbl[11] = '{11, 123, 25, 1, 25, 1};
    tbl[12] = '{3, 123, 253, 1, 253, 0};
    tbl[13] = '{13, 123, 253, 1, 253, 0};

    // Reset state, observed while reset is still asserted.
    #1 nrst = 1'b0;
    #1;
    chk("rst.op_valid", op_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.op_a", op_a, 0);
    chk("rst.op_b", op_b, 0);
    chk("rst.op_sub", op_sub, 0);
    chk("rst.disp", disp_value, 0);
    chk("rst.dovf", disp_ovf, 0);
    chk("rst.err", err, 0);
    tick();
    nrst = 1'b1;
    tick();

    press(5, 10, 1);
    chk("hold.op_a", op_a, 5);
    chk("hold.disp", disp_value, 5);

    do_reset();
    foreach (tbl[i]) begin
      press(tbl[i].code, 1, 1);
      chk($sformatf("tbl%0d.op_a", i), op_a, tbl[i].a);
      chk($sformatf("tbl%0d.op_b", i), op_b, tbl[i].b);
      chk($sformatf("tbl%0d.op_sub", i), op_sub, tbl[i].sub);
      chk($sformatf("tbl%0d.disp", i), disp_value, tbl[i].disp);
      chk($sformatf("tbl%0d.err", i), err, tbl[i].err);
      chk($sformatf("tbl%0d.valid", i), op_valid, 0);
    end

    // Full transaction with a stalled ALU.
    do_reset();
    press(1, 1, 1); press(2, 2, 1); press(10, 1, 2); press(7, 1, 1); press(12, 1, 1);
    for (int k = 0; k < 3; k++) begin
      chk("stall.valid", op_valid, 1);
      chk("stall.op_a", op_a, 12);
      chk("stall.op_b", op_b, 7);
      chk("stall.op_sub", op_sub, 0);
      chk("stall.busy", busy, 1);
      tick();
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("wait.valid", op_valid, 0);
    chk("wait.busy", busy, 1);
    res_value = 8'd19; res_ovf = 1'b0; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("res.disp", disp_value, 19);
    chk("res.busy", busy, 0);
`ifdef CALC_CHAIN_EN
    press(11, 1, 1); press(9, 1, 1); press(12, 1, 1);
    chk("chain.valid", op_valid, 1);
    chk("chain.op_a", op_a, 19);
    chk("chain.op_b", op_b, 9);
    chk("chain.op_sub", op_sub, 1);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    res_value = 8'd10; res_valid = 1'b1; tick(); res_valid = 1'b0;
    chk("chain.disp", disp_value, 10);
`else
    press(11, 1, 1);
    chk("nochain.disp", disp_value, 19);
    chk("nochain.op_a", op_a, 12);
    chk("nochain.busy", busy, 0);
`endif
    press(4, 1, 1);
    chk("new.op_a", op_a, 4);
    chk("new.disp", disp_value, 4);
    res_value = 8'd99; res_valid = 1'b1; tick(); res_valid = 1'b0;
    chk("stray_res.disp", disp_value, 4);

    // Async reset in the middle of a request.
    do_reset();
    press(3, 1, 1); press(10, 1, 1); press(4, 1, 1); press(12, 1, 1);
    chk("areset.pre_valid", op_valid, 1);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    chk("areset.valid", op_valid, 0);
    chk("areset.busy", busy, 0);
    tick();
    nrst = 1'b1;
    res_value = 8'd7; res_valid = 1'b1; tick(); res_valid = 1'b0;
    chk("areset.disp", disp_value, 0);

    // Randomized presses against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12) code = r % 10;
      else if (r < 14) code = 10;
      else if (r == 14) code = 11;
      else if (r < 17) code = 12;
      else if (r == 17) code = 15;
      else code = r - 5;
      press(code, $urandom_range(1, 3), $urandom_range(1, 2));
      m_key(code);
      check_all("rnd");
      if (m_ph == PA && $urandom_range(0, 7) == 0) begin
        res_value = W'($urandom); res_valid = 1'b1; tick(); res_valid = 1'b0;
        check_all("rnd_stray");
      end
      if (m_ph == PREQ) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          check_all("rnd_stall");
        end
        op_ready = 1'b1; tick(); op_ready = 1'b0;
        m_ph = PWAIT;
        check_all("rnd_wait");
        repeat ($urandom_range(0, 2)) tick();
        sum = m_sub ? (m_a - m_b) : (m_a + m_b);
        res_value = W'(sum & LIM);
        res_ovf = (sum < 0 || sum > LIM);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        m_res = sum & LIM; m_dovf = (sum < 0 || sum > LIM) ? 1 : 0; m_ph = PRES;
        check_all("rnd_res");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
